// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: FSM state encoding and the default
//               frame geometry used by the monitor-link receiver/transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 64;
  localparam int DATA_BITS_DEF    = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Generic 2-flop synchronizer with a parameterized reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input; both stages reset to RESET_VAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_m.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_m
// Description : Oversampling UART receiver (start / DATA_BITS / stop) for the
//               rx_m monitor line, with a valid/ready byte output, a framing
//               error pulse and an overrun pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_m
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 rx_m,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  uart_state_t          state;
  uart_state_t          state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 cnt_clr;
  logic                 idx_clr;
  logic                 shift_en;
  logic                 stop_ok;
  logic                 stop_bad;

  // Synchronizer idles high so a line held low through reset is not an edge.
  sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk_in),
    .rst_n (reset),
    .d     (rx_m),
    .q     (rx_s)
  );

  // FSM state register.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and per-cycle sampling strobes.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    idx_clr   = 1'b0;
    shift_en  = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_nxt = ST_START;
          cnt_clr   = 1'b1;
        end
      end
      ST_START: begin
        // Mid-bit check rejects glitches shorter than half a bit.
        if (cnt == CNT_HALF) begin
          if (rx_s) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_DATA;
            cnt_clr   = 1'b1;
            idx_clr   = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (cnt == CNT_LAST) begin
          shift_en = 1'b1;
          if (bit_idx == IDX_LAST) begin
            state_nxt = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (cnt == CNT_LAST) begin
          if (rx_s) begin
            stop_ok   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        // A break holds the line low; wait it out instead of retriggering.
        if (rx_s) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Bit-time counter, free-running and wrapping once per bit period.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt_clr || cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Data bit index and LSB-first shift register.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (idx_clr) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 1'b1;
      end
      if (shift_en) begin
        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
      end
    end
  end

  // Output byte register, handshake and error pulses.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (stop_ok) begin
        // A byte taken on this same edge frees the slot for the new one.
        if (!rx_valid || rx_ready) begin
          rx_data  <= shreg;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_m.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_m
// Description : Self-checking bench for uart_rx_m: directed frames with
//               hand-computed expectations plus randomized traffic, all
//               compared every cycle against a timestamp-based frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_m;
  import uart_pkg::*;

  localparam int C  = 64;
  localparam int DB = 8;
  localparam int M_LISTEN = 0;
  localparam int M_FRAME  = 1;
  localparam int M_BREAK  = 2;

  logic          clk_in   = 1'b0;
  logic          reset    = 1'b0;
  logic          rx_m     = 1'b1;
  logic          rx_ready = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  bit rand_rdy = 1'b0;

  uart_rx_m #(
    .CLKS_PER_BIT (C),
    .DATA_BITS    (DB)
  ) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .rx_m      (rx_m),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  // 20-unit clock period
  always #10 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The line value captured at every post-reset edge is logged; a frame is
  // recognised two edges after the line is first seen low (synchronizer),
  // and each bit k is read from the log at (detect + C/2 + k*C - 2).
  bit            hist [0:131071];
  int            t          = 0;
  int            valid_from = 0;
  bit            fresh      = 1'b1;
  int            mmode      = M_LISTEN;
  int            d_edge     = 0;
  logic          rs;
  bit            deliver;
  logic [DB-1:0] mb;
  logic [DB-1:0] m_data  = '0;
  logic          m_valid = 1'b0;
  logic          m_fe    = 1'b0;
  logic          m_ov    = 1'b0;

  always @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      mmode   = M_LISTEN;
      m_data  = '0;
      m_valid = 1'b0;
      m_fe    = 1'b0;
      m_ov    = 1'b0;
      fresh   = 1'b1;
    end else begin
      if (fresh) begin
        valid_from = t;
        fresh      = 1'b0;
      end
      hist[t] = rx_m;
      rs      = (t >= valid_from + 2) ? hist[t-2] : 1'b1;
      deliver = 1'b0;
      m_fe    = 1'b0;
      m_ov    = 1'b0;
      case (mmode)
        M_LISTEN: begin
          if (!rs) begin
            mmode  = M_FRAME;
            d_edge = t;
          end
        end
        M_FRAME: begin
          if (t == d_edge + C/2) begin
            if (rs) mmode = M_LISTEN;
          end else if (t == d_edge + C/2 + (DB+1)*C) begin
            for (int k = 1; k <= DB; k++) mb[k-1] = hist[d_edge + C/2 + k*C - 2];
            if (rs) begin
              deliver = 1'b1;
              mmode   = M_LISTEN;
            end else begin
              m_fe  = 1'b1;
              mmode = M_BREAK;
            end
          end
        end
        default: begin
          if (rs) mmode = M_LISTEN;
        end
      endcase
      if (deliver) begin
        if (!m_valid || rx_ready) begin
          m_data  = mb;
          m_valid = 1'b1;
        end else begin
          m_ov = 1'b1;
        end
      end else if (m_valid && rx_ready) begin
        m_valid = 1'b0;
      end
      t++;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk_in) begin
    if (reset) begin
      chk("cyc_rx_valid",  32'(rx_valid),  32'(m_valid));
      chk("cyc_rx_data",   32'(rx_data),   32'(m_data));
      chk("cyc_frame_err", 32'(frame_err), 32'(m_fe));
      chk("cyc_overrun",   32'(overrun),   32'(m_ov));
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_bit(input logic v);
    rx_m = v;
    repeat (C) begin
      @(negedge clk_in);
      if (rand_rdy) rx_ready = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input int stop_low);
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(b[i]);
    for (int i = 0; i < stop_low; i++) drive_bit(1'b0);
    drive_bit(1'b1);
  endtask

  task automatic idle(input int n);
    rx_m = 1'b1;
    repeat (n) begin
      @(negedge clk_in);
      if (rand_rdy) rx_ready = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic pulse_ready();
    @(negedge clk_in);
    rx_ready = 1'b1;
    @(negedge clk_in);
    rx_ready = 1'b0;
  endtask

  // Watchdog: the run must end on its own.
  initial begin
    #(20 * 200000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0;
    int ov0;
    int gap;
    int kind;

    // reset state
    #20;
    #1;
    chk("reset_rx_valid",  32'(rx_valid),  0);
    chk("reset_rx_data",   32'(rx_data),   0);
    chk("reset_frame_err", 32'(frame_err), 0);
    chk("reset_overrun",   32'(overrun),   0);
    @(negedge clk_in);
    reset = 1'b1;
    idle(5);

    // single byte 0x55, latency of 611 clocks from E0
    fork
      send_frame(8'h55, 0);
      begin
        repeat (610) @(negedge clk_in);
        chk("t1_valid_at_610", 32'(rx_valid), 0);
        @(negedge clk_in);
        chk("t1_valid_at_611", 32'(rx_valid), 1);
        chk("t1_data",         32'(rx_data),  32'h55);
      end
    join
    idle(100);
    chk("t1_valid_held", 32'(rx_valid), 1);
    chk("t1_data_held",  32'(rx_data),  32'h55);
    pulse_ready();
    chk("t1_valid_taken", 32'(rx_valid), 0);

    // glitch on idle line
    fe0  = fe_cnt;
    rx_m = 1'b0;
    repeat (10) @(negedge clk_in);
    idle(3 * C);
    chk("glitch_valid",   32'(rx_valid), 0);
    chk("glitch_fe",      32'(fe_cnt - fe0), 0);
    chk("glitch_in_idle", 32'(dut.state == ST_IDLE), 1);

    // framing error then a good frame
    fe0 = fe_cnt;
    send_frame(8'hA3, 3);
    chk("ferr_pulses", 32'(fe_cnt - fe0), 1);
    chk("ferr_valid",  32'(rx_valid), 0);
    send_frame(8'h3C, 0);
    chk("ferr_next_valid", 32'(rx_valid), 1);
    chk("ferr_next_data",  32'(rx_data),  32'h3C);
    pulse_ready();

    // overrun, back-to-back with nobody reading
    ov0 = ov_cnt;
    send_frame(8'h11, 0);
    send_frame(8'h22, 0);
    chk("ovr_pulses", 32'(ov_cnt - ov0), 1);
    chk("ovr_data",   32'(rx_data),  32'h11);
    chk("ovr_valid",  32'(rx_valid), 1);
    pulse_ready();
    chk("ovr_taken", 32'(rx_valid), 0);

    // ready asserted exactly on the second stop-sample edge
    ov0 = ov_cnt;
    fork
      begin
        send_frame(8'h11, 0);
        send_frame(8'h22, 0);
      end
      begin
        repeat (10 * C + 610) @(negedge clk_in);
        rx_ready = 1'b1;
        @(negedge clk_in);
        rx_ready = 1'b0;
        chk("swap_valid", 32'(rx_valid), 1);
        chk("swap_data",  32'(rx_data),  32'h22);
      end
    join
    chk("swap_no_ovr", 32'(ov_cnt - ov0), 0);
    pulse_ready();

    // reset in the middle of a frame while a byte is pending
    send_frame(8'h5A, 0);
    fork
      send_frame(8'h96, 0);
      begin
        repeat (C/2 + 5*C) @(negedge clk_in);
        #3;
        reset = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(rx_valid),  0);
        chk("rst_mid_data",  32'(rx_data),   0);
        chk("rst_mid_fe",    32'(frame_err), 0);
        chk("rst_mid_ov",    32'(overrun),   0);
      end
    join
    @(negedge clk_in);
    reset = 1'b1;
    idle(10);
    send_frame(8'hFF, 0);
    chk("rst_after_valid", 32'(rx_valid), 1);
    chk("rst_after_data",  32'(rx_data),  32'hFF);
    pulse_ready();

    // randomized traffic: good frames, bad stops, glitches, random ready
    rand_rdy = 1'b1;
    for (int n = 0; n < 30; n++) begin
      gap  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, C);
      idle(gap);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        rx_m = 1'b0;
        repeat ($urandom_range(1, C/2 - 4)) @(negedge clk_in);
        rx_m = 1'b1;
      end else if (kind == 1) begin
        send_frame(8'($urandom), $urandom_range(1, 2));
      end else begin
        send_frame(8'($urandom), 0);
      end
    end
    rand_rdy = 1'b0;
    rx_ready = 1'b0;
    idle(2 * C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_m.md
# uart_rx_m

Serial receiver for the `rx_m` line: oversamples the asynchronous input, frames start/8 data/stop, and presents each received byte to the CPU on a valid/ready handshake. It sits directly upstream of the `cpu` core's monitor-UART consumer. It is clocked by the 50 MHz board clock (20 ns); the default bit time of 64 clocks (1280 ns) matches the monitor link.

## Interface
Parameters:
- `CLKS_PER_BIT`, 64: clocks per serial bit; must be even and ≥ 4.
- `DATA_BITS`, 8: data bits per frame, LSB first.

Ports:
- `clk_in`  in  1: system clock; all flops on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `rx_m`  in  1: asynchronous serial input; idle is high.
- `rx_data`  out  DATA_BITS: received byte; stable while `rx_valid` is high.
- `rx_valid`  out  1: a byte is available.
- `rx_ready`  in  1: the consumer takes the byte when `rx_valid && rx_ready`.
- `frame_err`  out  1: 1-cycle pulse when a frame has a stop bit of 0.
- `overrun`  out  1: 1-cycle pulse when a completed byte is dropped.

## Operation
- **Synchronizer.** `rx_m` passes through a 2-flop synchronizer, giving `rx_s`. Both flops reset to 1 (idle), so releasing reset with the line low raises no spurious edge.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - **IDLE:** when `rx_s` is 0, go to START and clear the bit counter.
  - **START:** sample `rx_s` at mid-bit (counter = CLKS_PER_BIT/2−1).
    - If it is 1, this is a false start: return to IDLE with no output.
    - If it is 0, go to DATA and clear the counter and the bit index.
  - **DATA:** sample every CLKS_PER_BIT clocks and shift right into the shift register (LSB first). After DATA_BITS samples, go to STOP.
  - **STOP:** sample CLKS_PER_BIT clocks after the last data sample.
    - If it is 1, deliver the byte (see delivery) and go to IDLE.
    - If it is 0, pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
  - **WAIT_HIGH:** stay until `rx_s` is 1, then go to IDLE. This rejects a break condition without retriggering.
- **Delivery** happens at the stop-sample edge:
  - If `rx_valid` is 0, or `rx_valid && rx_ready` in the same cycle: load `rx_data` and set `rx_valid`.
  - Otherwise: keep the old byte and `rx_valid`, and pulse `overrun`.
- **Handshake.** `rx_valid` clears on the edge where `rx_valid && rx_ready` holds, unless a new byte loads on that same edge, in which case it stays 1. `rx_ready` has no effect while `rx_valid` is 0.
- **Counter width.** The counter is `$clog2(CLKS_PER_BIT)` bits and wraps to 0 at CLKS_PER_BIT−1. The bit index is `$clog2(DATA_BITS+1)` bits.
- **Reset mid-frame:** the FSM returns to IDLE, the partial byte is lost, and all outputs are forced to their reset values.

## Timing
- Reset values:
  - `rx_data` = 0, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0.
  - FSM = IDLE, synchronizer flops = 1, counter = 0.
- Let E0 be the first rising edge that samples `rx_m` = 0. With C = CLKS_PER_BIT, bit k (0 = start, 1..DATA_BITS = data, DATA_BITS+1 = stop) is sampled at edge E0 + 2 + C/2 + k·C.
- Default latency: stop sample at E0+610; `rx_valid`, `frame_err` or `overrun` is high in the cycle after that edge. This is 611 clocks, about 12.22 µs.
- Back-to-back frames:
  - The earliest next start is recognized in IDLE at the edge after the stop sample.
  - Consecutive frames with zero-length idle are supported.
  - Throughput is one byte per (DATA_BITS+2)·C clocks.
- `frame_err` and `overrun` are never high simultaneously and last exactly one cycle each.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding: `ST_IDLE`, `ST_START`, `ST_DATA`, `ST_STOP`, `ST_WAIT_HIGH`.
  - Default `CLKS_PER_BIT_DEF` = 64, `DATA_BITS_DEF` = 8.
  - The future `uart_tx_m` reuses these.
- Sub-module `sync2`: a generic 2-flop synchronizer with a parameterized reset value. It is instantiated with reset value 1.
- Everything else is flat in `uart_rx_m`: counter, bit index, shift register, FSM and output registers.

## Test plan
- **Single byte.** Hold `reset` low 20 ns, then release. Drive `rx_m` = 0,1,0,1,0,1,0,1,0,1 at 1280 ns per bit, with `rx_ready` = 0.
  - Expect `rx_data` = 0x55 and `rx_valid` = 1 exactly 611 clocks after E0.
  - `rx_valid` stays high and `rx_data` stays stable until `rx_ready` is pulsed, then `rx_valid` = 0.
- **Glitch.** Drive a 10-clock low pulse on an idle line.
  - No `rx_valid`, no `frame_err`; the FSM is back in IDLE.
- **Framing error.** Send 0xA3 with the stop bit held 0 for 3 bit times.
  - `frame_err` pulses once and `rx_valid` stays 0.
  - A following valid 0x3C frame is received correctly.
- **Overrun.** Send 0x11 then 0x22 back-to-back with `rx_ready` = 0.
  - `overrun` pulses at the second stop sample and `rx_data` stays 0x11.
  - Repeat with `rx_ready` = 1 on the exact stop-sample cycle: 0x22 loads, `rx_valid` stays 1, and there is no overrun.
- **Reset mid-frame.** Assert `reset` low during data bit 4 of a frame.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release with the line idle, a new 0xFF frame is received correctly.
